ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 command transmitter, the transmit companion to the keyboard receive path. It accepts one byte from the CPU-side controller (LED set 0xED, reset 0xFF, enable 0xF4, and so on) and performs the full PS/2 host request sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop, and device ack check. Pads are open-drain through output-enable pins; the top level ties them to the shared ps2_clk_/ps2_data_ lines.

Parameters:
TIMER_100USEC_VALUE_PP, 3200, sys_clks held in clock inhibit (100 us at 32 MHz)
TIMER_100USEC_BITS_PP, 12, width of inhibit timer
TIMER_5USEC_VALUE_PP, 160, sys_clks from data-low to clock release
TIMER_WATCHDOG_VALUE_PP, 480000, sys_clks allowed from clock release to ack (15 ms)
TIMER_WATCHDOG_BITS_PP, 19, width of watchdog timer

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
tx_data  in  8  byte to send
tx_valid  in  1  request; accepted when tx_valid && tx_ready
tx_ready  out  1  high only in IDLE
tx_done  out  1  one-cycle pulse: device acked
tx_error  out  1  one-cycle pulse: no ack or watchdog expiry
rx_inhibit  out  1  high from INHIBIT through RECOVER; receiver ignores the line
ps2_clk_i  in  1  raw clock pad input
ps2_data_i  in  1  raw data pad input
ps2_clk_oe  out  1  1 = pull clock low
ps2_data_oe  out  1  1 = pull data low

Behaviour:
- Reset (async assert, sync release): state IDLE; tx_ready=1; tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_data_oe=0; timers and bit counter=0. Mid-frame reset releases both pads immediately.
- Inputs pass through a 2-flop synchronizer. A falling edge (fall) and a rising edge (rise) are each 1-cycle strobes from the synced clock.
- Accept: latch shift register {1'b1 stop, ~^tx_data parity, tx_data}. tx_valid while busy is ignored. The host has priority, so the request is accepted even if the device is mid-frame.
- IDLE: accept -> INHIBIT.
- INHIBIT: clk_oe=1; count TIMER_100USEC_VALUE_PP cycles -> REQ.
- REQ: clk_oe=1, data_oe=1 (start bit); count TIMER_5USEC_VALUE_PP cycles -> SHIFT. Release clk_oe, start watchdog, bit_count=0.
- SHIFT: on each fall, drive shift[0] (data_oe = ~shift[0]), shift right, bit_count+1. Ten falls cover 8 data bits, parity and stop (stop drives data_oe=0, releasing the line). The fall after bit_count==10 -> ACK.
- ACK: at that 11th fall, sample synced data. Data 0 -> RECOVER with ack_ok=1. Data 1 -> RECOVER with ack_ok=0.
- RECOVER: wait for synced clk=1 and data=1. Then pulse tx_done (ack_ok) or tx_error, and return to IDLE; tx_ready rises the cycle after the pulse.
- Watchdog: runs from REQ exit to RECOVER exit. Expiry in any state -> release pads, pulse tx_error, IDLE.
- Data pad changes only while synced clock is low, never on rise.
- rise is used only for the watchdog-free glitch check: a rise with no preceding fall is ignored.

Optional Feature:
PS2_TX_RESEND_EN
- Defined: the first failure (no ack or watchdog) re-enters INHIBIT with the latched byte, one retry only. tx_error pulses only if the retry also fails.
- Undefined: any failure pulses tx_error immediately; no retry counter is synthesized.

Decomposition:
- ps2_pkg holds the state enumeration (IDLE, INHIBIT, REQ, SHIFT, ACK, RECOVER), FRAME_BITS=11, default timer constants, and the odd-parity function.
- One sub-module, ps2_line_sync: 2-flop synchronizer plus fall/rise strobes for clk and data. It is reused later by a receiver rewrite.

Test Plan:
- Send 0xED; device model clocks at 12.5 kHz and acks. Required: clk_oe low for ≥3200 cycles; serial bits 1,0,1,1,0,1,1,1; parity 1; stop 1; one tx_done pulse; tx_ready back to 1.
- Send 0xF4. Required: parity bit 0 and tx_done. Assert tx_valid again during the frame: it is ignored and no second frame starts.
- Device never clocks. Required: tx_error exactly 480000 cycles after clock release; both oe low. With PS2_TX_RESEND_EN, a second inhibit occurs first and tx_error comes only after it also fails.
- Device clocks 11 times but leaves data high at the 11th fall. Required: tx_error, no tx_done.
- Assert reset low at bit 4 of 0xFF. Required: both oe=0 the same cycle (async); then a fresh 0x00 send completes with parity 1 and tx_done.
- Device mid-scancode when tx_valid rises. Required: inhibit starts immediately; rx_inhibit=1 until RECOVER exits.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg : shared definitions for the PS/2 host transmit path.
//
// Contents:
//   tx_state_e      - transmitter state enumeration
//   FRAME_BITS      - clock falls per host-to-device frame
//                     (8 data + parity + stop + ack)
//   DEF_TIMER_*     - default timer constants for a 32 MHz system clock
//   odd_parity()    - PS/2 odd parity bit for one data byte
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        RECOVER
    } tx_state_e;

    localparam int FRAME_BITS = 11;

    localparam int DEF_TIMER_100USEC_VALUE  = 3200;
    localparam int DEF_TIMER_100USEC_BITS   = 12;
    localparam int DEF_TIMER_5USEC_VALUE    = 160;
    localparam int DEF_TIMER_WATCHDOG_VALUE = 480000;
    localparam int DEF_TIMER_WATCHDOG_BITS  = 19;

    // The parity bit makes the total count of ones across data + parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if : byte-request handshake between the CPU-side controller
// and the PS/2 host transmitter.
//
// Signals:
//   tx_data   byte to send (controller -> transmitter)
//   tx_valid  send request, taken when tx_valid && tx_ready
//   tx_ready  transmitter idle and able to take a byte
//   tx_done   one-cycle pulse, device acknowledged the byte
//   tx_error  one-cycle pulse, no acknowledge or watchdog expiry
//
// Modports: master = controller side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done,
        output tx_error
    );

endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync : brings the raw PS/2 clock and data pads into the system
// clock domain and derives one-cycle edge strobes from the synced clock.
//
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   clk_pad_i       raw PS/2 clock pad
//   data_pad_i      raw PS/2 data pad
//   clk_sync_o      clock after two flops
//   data_sync_o     data after two flops
//   clk_fall_o      one-cycle strobe on a synced clock high->low
//   clk_rise_o      one-cycle strobe on a synced clock low->high
// ---------------------------------------------------------------------------
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic clk_pad_i,
    input  logic data_pad_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic clk_fall_o,
    output logic clk_rise_o
);

    logic [1:0] clkPipe_q;
    logic [1:0] dataPipe_q;
    logic       clkPrev_q;

    // Idle PS/2 lines float high, so the pipes reset to 1 and no edge is
    // seen when reset releases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clkPipe_q  <= 2'b11;
            dataPipe_q <= 2'b11;
            clkPrev_q  <= 1'b1;
        end else begin
            clkPipe_q  <= {clkPipe_q[0], clk_pad_i};
            dataPipe_q <= {dataPipe_q[0], data_pad_i};
            clkPrev_q  <= clkPipe_q[1];
        end
    end

    assign clk_sync_o  = clkPipe_q[1];
    assign data_sync_o = dataPipe_q[1];
    assign clk_fall_o  = clkPrev_q & ~clkPipe_q[1];
    assign clk_rise_o  = ~clkPrev_q & clkPipe_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx : PS/2 host-to-device command transmitter.
//
// Runs the full host request: clock inhibit, start bit, 8 data bits LSB
// first, odd parity, stop, then checks the device acknowledge. Pads are
// open-drain; *_oe = 1 pulls the line low.
//
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   tx              ps2_host_tx_if.slave (tx_data/tx_valid/tx_ready/
//                   tx_done/tx_error)
//   rx_inhibit      high while a host frame is in progress
//   ps2_clk_i       raw clock pad input
//   ps2_data_i      raw data pad input
//   ps2_clk_oe      1 = pull clock low
//   ps2_data_oe     1 = pull data low
//
// Build option: PS2_TX_RESEND_EN - when defined, the first failure of a
// byte (no ack or watchdog expiry) re-runs the whole frame once before
// tx_error is reported.
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int TIMER_100USEC_VALUE_PP  = DEF_TIMER_100USEC_VALUE,
    parameter int TIMER_100USEC_BITS_PP   = DEF_TIMER_100USEC_BITS,
    parameter int TIMER_5USEC_VALUE_PP    = DEF_TIMER_5USEC_VALUE,
    parameter int TIMER_WATCHDOG_VALUE_PP = DEF_TIMER_WATCHDOG_VALUE,
    parameter int TIMER_WATCHDOG_BITS_PP  = DEF_TIMER_WATCHDOG_BITS
) (
    input  logic            clk,
    input  logic            reset,
    ps2_host_tx_if.slave    tx,
    output logic            rx_inhibit,
    input  logic            ps2_clk_i,
    input  logic            ps2_data_i,
    output logic            ps2_clk_oe,
    output logic            ps2_data_oe
);

    localparam int SHIFT_BITS = FRAME_BITS - 1;

    localparam logic [TIMER_100USEC_BITS_PP-1:0] INHIBIT_LAST =
        TIMER_100USEC_BITS_PP'(TIMER_100USEC_VALUE_PP - 1);
    localparam logic [TIMER_100USEC_BITS_PP-1:0] REQ_LAST =
        TIMER_100USEC_BITS_PP'(TIMER_5USEC_VALUE_PP - 1);
    localparam logic [TIMER_WATCHDOG_BITS_PP-1:0] WD_LIMIT =
        TIMER_WATCHDOG_BITS_PP'(TIMER_WATCHDOG_VALUE_PP);
    localparam logic [3:0] LAST_BIT = 4'(SHIFT_BITS);

    tx_state_e                         state_q, state_d;
    logic [TIMER_100USEC_BITS_PP-1:0]  timer_q, timer_d;
    logic [TIMER_WATCHDOG_BITS_PP-1:0] wdCount_q, wdCount_d;
    logic [3:0]                        bitCount_q, bitCount_d;
    logic [SHIFT_BITS-1:0]             shift_q, shift_d;
    logic                              dataOe_q, dataOe_d;
    logic                              ackOk_q, ackOk_d;
    logic                              armed_q, armed_d;
`ifdef PS2_TX_RESEND_EN
    logic                              retry_q, retry_d;
    logic [7:0]                        txByte_q, txByte_d;
`endif

    logic clkSync, dataSync, clkFall, clkRise;
    logic wdActive, fail, txDone, txError;

    ps2_line_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .clk_pad_i   (ps2_clk_i),
        .data_pad_i  (ps2_data_i),
        .clk_sync_o  (clkSync),
        .data_sync_o (dataSync),
        .clk_fall_o  (clkFall),
        .clk_rise_o  (clkRise)
    );

    // The watchdog covers the device-clocked part of the frame, from clock
    // release until the line has returned to idle.
    assign wdActive = (state_q == SHIFT) || (state_q == ACK) || (state_q == RECOVER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            wdCount_q  <= '0;
            bitCount_q <= '0;
            shift_q    <= '0;
            dataOe_q   <= 1'b0;
            ackOk_q    <= 1'b0;
            armed_q    <= 1'b1;
`ifdef PS2_TX_RESEND_EN
            retry_q    <= 1'b0;
            txByte_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            wdCount_q  <= wdCount_d;
            bitCount_q <= bitCount_d;
            shift_q    <= shift_d;
            dataOe_q   <= dataOe_d;
            ackOk_q    <= ackOk_d;
            armed_q    <= armed_d;
`ifdef PS2_TX_RESEND_EN
            retry_q    <= retry_d;
            txByte_q   <= txByte_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        wdCount_d  = wdCount_q;
        bitCount_d = bitCount_q;
        shift_d    = shift_q;
        dataOe_d   = dataOe_q;
        ackOk_d    = ackOk_q;
        armed_d    = armed_q;
`ifdef PS2_TX_RESEND_EN
        retry_d    = retry_q;
        txByte_d   = txByte_q;
`endif
        txDone     = 1'b0;
        txError    = 1'b0;
        fail       = 1'b0;

        // A fall is only acted on once per low phase: it disarms until the
        // next rise, and a rise with no fall before it changes nothing.
        if (clkFall) begin
            armed_d = 1'b0;
        end else if (clkRise) begin
            armed_d = 1'b1;
        end

        if (wdActive) begin
            wdCount_d = wdCount_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                timer_d   = '0;
                wdCount_d = '0;
                // The host has priority, so a request is taken even while
                // the device is in the middle of its own frame.
                if (tx.tx_valid) begin
                    state_d = INHIBIT;
                    shift_d = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
`ifdef PS2_TX_RESEND_EN
                    retry_d  = 1'b0;
                    txByte_d = tx.tx_data;
`endif
                end
            end
            INHIBIT: begin
                if (timer_q == INHIBIT_LAST) begin
                    state_d  = REQ;
                    timer_d  = '0;
                    dataOe_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REQ: begin
                if (timer_q == REQ_LAST) begin
                    state_d    = SHIFT;
                    timer_d    = '0;
                    wdCount_d  = '0;
                    bitCount_d = '0;
                    armed_d    = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SHIFT: begin
                // Ten falls put out data, parity and stop; the eleventh is
                // the device acknowledge, with data low meaning success.
                if (clkFall && armed_q) begin
                    if (bitCount_q == LAST_BIT) begin
                        state_d = ACK;
                        ackOk_d = ~dataSync;
                    end else begin
                        dataOe_d   = ~shift_q[0];
                        shift_d    = {1'b0, shift_q[SHIFT_BITS-1:1]};
                        bitCount_d = bitCount_q + 4'd1;
                    end
                end
            end
            ACK: begin
                state_d = RECOVER;
            end
            RECOVER: begin
                if (clkSync && dataSync) begin
                    if (ackOk_q) begin
                        txDone  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog expiry overrides whatever the frame was doing.
        if (wdActive && (wdCount_q == WD_LIMIT)) begin
            fail   = 1'b1;
            txDone = 1'b0;
        end

        if (fail) begin
            dataOe_d  = 1'b0;
            timer_d   = '0;
            wdCount_d = '0;
`ifdef PS2_TX_RESEND_EN
            if (!retry_q) begin
                retry_d = 1'b1;
                state_d = INHIBIT;
                shift_d = {1'b1, odd_parity(txByte_q), txByte_q};
            end else begin
                txError = 1'b1;
                state_d = IDLE;
            end
`else
            txError = 1'b1;
            state_d = IDLE;
`endif
        end
    end

    assign tx.tx_ready = (state_q == IDLE);
    assign tx.tx_done  = txDone;
    assign tx.tx_error = txError;
    assign rx_inhibit  = (state_q != IDLE);
    assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
    assign ps2_data_oe = dataOe_q;

endmodule
